ifu_idu_queue: RTL and testbench



---
 rtl/ifu_idu_queue.sv | 90 +++++++++
 tb/tb_ifu_idu_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ifu_idu_queue.sv
// Circular instruction queue between fetch and decode.
// Head entry is read combinationally; pushes appear one cycle later.
module ifu_idu_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      inst_i,
  input  logic [ADDR_W-1:0]      inst_addr_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      inst_o,
  output logic [ADDR_W-1:0]      inst_addr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count_q;

  always_comb begin
    inst_o      = NOP_INST;
    inst_addr_o = '0;
    if (out_valid_o) begin
      inst_o      = mem_q[rd_ptr_q].inst;
      inst_addr_o = mem_q[rd_ptr_q].addr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; a flushed write lands in a slot that is dead
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{inst: inst_i, addr: inst_addr_i};
    end
  end

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Bench for ifu_idu_queue: queue-based reference model checked every
// cycle, plus directed literal expectations.
module tb_ifu_idu_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;

  ifu_idu_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INST(32'h00000013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .inst_i(inst_i),
    .inst_addr_i(inst_addr_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .inst_o(inst_o),
    .inst_addr_o(inst_addr_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  ent_t mq[$];
  bit   started = 0;

  // Reference: a plain FIFO of accepted fetches
  always @(posedge clk) begin
    bit acc, take;
    started = 1;
    if (rst || flush_i) begin
      mq.delete();
    end else begin
      acc  = in_valid_i && (mq.size() < DEPTH);
      take = out_ready_i && (mq.size() > 0);
      if (take) void'(mq.pop_front());
      if (acc) mq.push_back('{inst: inst_i, addr: inst_addr_i});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [31:0] ei, ea;
      ei = (mq.size() != 0) ? mq[0].inst : 32'h00000013;
      ea = (mq.size() != 0) ? mq[0].addr : 32'h0;
      chk("m_valid", 64'(out_valid_o), 64'(mq.size() != 0));
      chk("m_ready", 64'(in_ready_o), 64'(mq.size() < DEPTH));
      chk("m_count", 64'(count_o), 64'(mq.size()));
      chk("m_inst", 64'(inst_o), 64'(ei));
      chk("m_addr", 64'(inst_addr_o), 64'(ea));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] in,
                     input logic [31:0] ad, input logic ordy,
                     input logic fl, input logic r);
    in_valid_i  = v;
    inst_i      = in;
    inst_addr_i = ad;
    out_ready_i = ordy;
    flush_i     = fl;
    rst         = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'h13);
    chk("rst_addr", 64'(inst_addr_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);

    cyc(1, 32'h00500093, 32'h100, 1, 0, 0);
    chk("one_valid", 64'(out_valid_o), 64'd1);
    chk("one_inst", 64'(inst_o), 64'h00500093);
    chk("one_addr", 64'(inst_addr_o), 64'h100);
    cyc(0, 0, 0, 1, 0, 0);
    chk("one_cnt0", 64'(count_o), 64'd0);
    chk("one_nop", 64'(inst_o), 64'h13);

    for (int k = 0; k < 4; k++)
      cyc(1, 32'h10000000 + k, 32'(4 * k), 0, 0, 0);
    chk("full_cnt", 64'(count_o), 64'd4);
    chk("full_rdy", 64'(in_ready_o), 64'd0);
    cyc(1, 32'hdeadbeef, 32'h10, 0, 0, 0);
    chk("refuse_cnt", 64'(count_o), 64'd4);
    chk("refuse_head", 64'(inst_addr_o), 64'h0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_addr", 64'(inst_addr_o), 64'(4 * k));
      cyc(0, 0, 0, 1, 0, 0);
      if (k == 0) begin
        chk("drain_rdy", 64'(in_ready_o), 64'd1);
        chk("drain_cnt", 64'(count_o), 64'd3);
      end
    end
    chk("drain_empty", 64'(count_o), 64'd0);

    for (int k = 0; k < 10; k++) begin
      cyc(1, 32'h20000000 + k, 32'h200 + 32'(4 * k), 1, 0, 0);
      chk("strm_cnt", 64'(count_o), 64'd1);
      chk("strm_addr", 64'(inst_addr_o), 64'(32'h200 + 4 * k));
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("strm_end", 64'(count_o), 64'd0);

    for (int k = 0; k < 3; k++)
      cyc(1, 32'h30000000 + k, 32'h400 + 32'(4 * k), 0, 0, 0);
    chk("pre_fl_cnt", 64'(count_o), 64'd3);
    cyc(1, 32'h3000abcd, 32'h300, 1, 1, 0);
    chk("fl_cnt", 64'(count_o), 64'd0);
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_inst", 64'(inst_o), 64'h13);
    cyc(0, 0, 0, 1, 0, 0);
    chk("fl_after", 64'(count_o), 64'd0);

    cyc(1, 32'h40000000, 32'h500, 0, 0, 0);
    cyc(1, 32'h40000001, 32'h504, 0, 0, 0);
    chk("pre_rst_cnt", 64'(count_o), 64'd2);
    cyc(1, 32'h40000002, 32'h508, 1, 0, 1);
    chk("mrst_valid", 64'(out_valid_o), 64'd0);
    chk("mrst_cnt", 64'(count_o), 64'd0);
    chk("mrst_inst", 64'(inst_o), 64'h13);
    chk("mrst_addr", 64'(inst_addr_o), 64'h0);
    chk("mrst_rdy", 64'(in_ready_o), 64'd1);
    cyc(1, 32'h00a00113, 32'h600, 0, 0, 0);
    chk("post_cnt", 64'(count_o), 64'd1);
    chk("post_inst", 64'(inst_o), 64'h00a00113);
    chk("post_addr", 64'(inst_addr_o), 64'h600);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
